// File: rtl/fp_coprocessor_mc_pkg.sv
// Shared definitions for the multi-cycle COP1 floating-point coprocessor:
// instruction layout, decode constants, FPU operation codes and FSM states.
package fpc_pkg;

    localparam logic [5:0] COP1_OPCODE = 6'h11;

    // fp_opcode (fmt) field values
    localparam logic [4:0] FMT_MTC1 = 5'h04;
    localparam logic [4:0] FMT_S    = 5'h10;

    // funct field values for single-precision ops
    localparam logic [5:0] FUNCT_ADD  = 6'h00;
    localparam logic [5:0] FUNCT_SUB  = 6'h01;
    localparam logic [5:0] FUNCT_ABS  = 6'h05;
    localparam logic [5:0] FUNCT_MOV  = 6'h06;
    localparam logic [5:0] FUNCT_NEG  = 6'h07;
    localparam logic [5:0] FUNCT_C_EQ = 6'h32;
    localparam logic [5:0] FUNCT_C_LT = 6'h3C;
    localparam logic [5:0] FUNCT_C_LE = 6'h3E;

    // Condition-code index lives in the upper bits of the fd field
    localparam int CC_MSB = 4;
    localparam int CC_LSB = 2;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MOV = 3'd2,
        FPU_NEG = 3'd3,
        FPU_ABS = 3'd4,
        FPU_CEQ = 3'd5,
        FPU_CLT = 3'd6,
        FPU_CLE = 3'd7
    } fpu_op_e;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 1'b0;
    localparam fsm_state_t ST_EXEC = 1'b1;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] fp_opcode;
        logic [4:0] ft;
        logic [4:0] fs;
        logic [4:0] fd;
        logic [5:0] funct;
    } cop1_inst_t;

endpackage

// File: rtl/fp_coprocessor_mc_if.sv
// Core-to-coprocessor bus: instruction handshake, GPR data path and status.
interface fp_coprocessor_mc_if #(
    parameter int FLAG_COUNT = 8
);
    logic [31:0]           inst;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [31:0]           data_in;
    logic [31:0]           data_out;
    logic [FLAG_COUNT-1:0] flags;
    logic                  busy;
    logic                  done;

    modport master (
        output inst, inst_valid, data_in,
        input  inst_ready, data_out, flags, busy, done
    );

    modport slave (
        input  inst, inst_valid, data_in,
        output inst_ready, data_out, flags, busy, done
    );
endinterface

// File: rtl/fp_coprocessor_mc_decoder.sv
// COP1 instruction decoder: maps fmt/funct to write enables and an FPU op.
module fpc_instruction_decoder
    import fpc_pkg::*;
(
    input  logic [4:0] fp_opcode_i,
    input  logic [5:0] funct_i,
    output logic       reg_wr_en_o,
    output logic       cc_wr_en_o,
    output fpu_op_e    fpu_op_o,
    output logic       from_processor_o
);

    // Decode the instruction class; unknown encodings produce no enables
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        reg_wr_en_o      = 1'b0;
        cc_wr_en_o       = 1'b0;
        fpu_op_o         = FPU_ADD;
        from_processor_o = 1'b0;
        if (fp_opcode_i == FMT_MTC1) begin
            reg_wr_en_o      = 1'b1;
            from_processor_o = 1'b1;
        end else if (fp_opcode_i == FMT_S) begin
            case (funct_i)
                FUNCT_ADD:  begin reg_wr_en_o = 1'b1; fpu_op_o = FPU_ADD; end
                FUNCT_SUB:  begin reg_wr_en_o = 1'b1; fpu_op_o = FPU_SUB; end
                FUNCT_ABS:  begin reg_wr_en_o = 1'b1; fpu_op_o = FPU_ABS; end
                FUNCT_MOV:  begin reg_wr_en_o = 1'b1; fpu_op_o = FPU_MOV; end
                FUNCT_NEG:  begin reg_wr_en_o = 1'b1; fpu_op_o = FPU_NEG; end
                FUNCT_C_EQ: begin cc_wr_en_o  = 1'b1; fpu_op_o = FPU_CEQ; end
                FUNCT_C_LT: begin cc_wr_en_o  = 1'b1; fpu_op_o = FPU_CLT; end
                FUNCT_C_LE: begin cc_wr_en_o  = 1'b1; fpu_op_o = FPU_CLE; end
                default:    ;
            endcase
        end
    end

endmodule

// File: rtl/fp_coprocessor_mc_exec_unit.sv
// Execute stage: latches operands at accept, counts down the FPU latency and
// raises a one-cycle write strobe with the destination and result.
module fpc_exec_unit
    import fpc_pkg::*;
#(
    parameter int FPU_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  fpu_op_e     op_i,
    input  logic [4:0]  fd_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        reg_we_i,
    input  logic        cc_we_i,
    output logic        busy_o,
    output logic        reg_wr_o,
    output logic        cc_wr_o,
    output logic [4:0]  fd_o,
    output logic [2:0]  cc_o,
    output logic [31:0] result_o
);

    localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FPU_LATENCY - 1);

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fpu_op_e          op_q;
    logic [4:0]       fd_q;
    logic [31:0]      a_q, b_q;
    logic             reg_we_q, cc_we_q;
    logic             finish;

    assign finish   = (state_q == ST_EXEC) && (cnt_q == '0);
    assign busy_o   = (state_q == ST_EXEC);
    assign reg_wr_o = finish && reg_we_q;
    assign cc_wr_o  = finish && cc_we_q;
    assign fd_o     = fd_q;
    assign cc_o     = fd_q[CC_MSB:CC_LSB];

    fpu u_fpu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (result_o)
    );

    // Next-state: enter EXEC on start, count down, leave when the count hits 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_EXEC;
                cnt_d   = CNT_LOAD;
            end
            default: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                     else             state_d = ST_IDLE;
        endcase
    end

    // State, counter and operand latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= FPU_ADD;
            fd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            reg_we_q <= 1'b0;
            cc_we_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_i && state_q == ST_IDLE) begin
                op_q     <= op_i;
                fd_q     <= fd_i;
                a_q      <= a_i;
                b_q      <= b_i;
                reg_we_q <= reg_we_i;
                cc_we_q  <= cc_we_i;
            end
        end
    end

endmodule

// File: rtl/fp_coprocessor_mc_fpu.sv
// Combinational single-precision FPU: add/sub (truncating, denormals flushed
// to zero, no NaN/Inf handling), mov/neg/abs and ordered compares.
module fpu
    import fpc_pkg::*;
(
    input  fpu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    logic [7:0]  ea, eb, big_e, small_e, diff_e, res_e;
    logic [23:0] ma, mb, big_m, small_m, small_sh, norm;
    logic        sb, big_s, small_s, res_s;
    logic [24:0] sum;
    logic [31:0] add_res;
    logic        a_zero, b_zero, eq, lt;

    // Magnitude-ordered add/subtract with a normalisation shift
    always_comb begin
        ea = a_i[30:23];
        eb = b_i[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, a_i[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, b_i[22:0]};
        sb = b_i[31] ^ (op_i == FPU_SUB);
        if ({ea, ma} >= {eb, mb}) begin
            big_e = ea; big_m = ma; big_s = a_i[31];
            small_e = eb; small_m = mb; small_s = sb;
        end else begin
            big_e = eb; big_m = mb; big_s = sb;
            small_e = ea; small_m = ma; small_s = a_i[31];
        end
        diff_e   = big_e - small_e;
        small_sh = (diff_e > 8'd23) ? 24'd0 : (small_m >> diff_e);
        res_s    = big_s;
        res_e    = big_e;
        if (big_s == small_s) begin
            sum = {1'b0, big_m} + {1'b0, small_sh};
            if (sum[24]) begin
                norm  = sum[24:1];
                res_e = big_e + 8'd1;
            end else begin
                norm  = sum[23:0];
            end
        end else begin
            sum  = {1'b0, big_m} - {1'b0, small_sh};
            norm = sum[23:0];
            for (int i = 0; i < 23; i++) begin
                if (!norm[23] && norm != 24'd0) begin
                    norm  = norm << 1;
                    res_e = res_e - 8'd1;
                end
            end
        end
        add_res = (norm == 24'd0) ? 32'd0 : {res_s, res_e, norm[22:0]};
    end

    // Compare: +0 and -0 are equal; otherwise sign-magnitude ordering
    always_comb begin
        a_zero = (a_i[30:0] == 31'd0);
        b_zero = (b_i[30:0] == 31'd0);
        eq     = (a_i == b_i) || (a_zero && b_zero);
        if (a_zero && b_zero)     lt = 1'b0;
        else if (a_i[31] != b_i[31]) lt = a_i[31];
        else if (!a_i[31])        lt = (a_i[30:0] < b_i[30:0]);
        else                      lt = (a_i[30:0] > b_i[30:0]);
    end

    // Result select
    always_comb begin
        case (op_i)
            FPU_ADD, FPU_SUB: result_o = add_res;
            FPU_MOV:          result_o = a_i;
            FPU_NEG:          result_o = {~a_i[31], a_i[30:0]};
            FPU_ABS:          result_o = {1'b0, a_i[30:0]};
            FPU_CEQ:          result_o = {31'd0, eq};
            FPU_CLT:          result_o = {31'd0, lt};
            default:          result_o = {31'd0, lt | eq};
        endcase
    end

endmodule

// File: rtl/fp_coprocessor_mc.sv
// Multi-cycle COP1 coprocessor top: register file, condition flags,
// instruction handshake and the done pulse around the execute unit.
module fp_coprocessor_mc
    import fpc_pkg::*;
#(
    parameter int REG_COUNT   = 32,
    parameter int FLAG_COUNT  = 8,
    parameter int FPU_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_coprocessor_mc_if.slave  bus
);

    cop1_inst_t            inst;
    logic [31:0]           regs_q [REG_COUNT];
    logic [FLAG_COUNT-1:0] flags_q;
    logic                  done_q;

    logic        reg_wr_en, cc_wr_en, from_processor;
    fpu_op_e     fpu_op;
    logic        busy, accept, move_wr, start;
    logic [31:0] rs_data, rt_data;
    logic        ex_reg_wr, ex_cc_wr;
    logic [4:0]  ex_fd;
    logic [2:0]  ex_cc;
    logic [31:0] ex_result;
    logic        rf_we;
    logic [4:0]  rf_idx;
    logic [31:0] rf_data;

    assign inst    = bus.inst;
    assign accept  = bus.inst_valid && !busy && (inst.opcode == COP1_OPCODE);
    assign move_wr = accept && from_processor;
    assign start   = accept && !from_processor && (reg_wr_en || cc_wr_en);

    assign bus.inst_ready = !busy;
    assign bus.busy       = busy;
    assign bus.data_out   = rs_data;
    assign bus.flags      = flags_q;
    assign bus.done       = done_q;

    fpc_instruction_decoder u_dec (
        .fp_opcode_i      (inst.fp_opcode),
        .funct_i          (inst.funct),
        .reg_wr_en_o      (reg_wr_en),
        .cc_wr_en_o       (cc_wr_en),
        .fpu_op_o         (fpu_op),
        .from_processor_o (from_processor)
    );

    fpc_exec_unit #(.FPU_LATENCY(FPU_LATENCY)) u_exec (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (fpu_op),
        .fd_i     (inst.fd),
        .a_i      (rs_data),
        .b_i      (rt_data),
        .reg_we_i (reg_wr_en),
        .cc_we_i  (cc_wr_en),
        .busy_o   (busy),
        .reg_wr_o (ex_reg_wr),
        .cc_wr_o  (ex_cc_wr),
        .fd_o     (ex_fd),
        .cc_o     (ex_cc),
        .result_o (ex_result)
    );

    // Register reads; an out-of-range index matches no entry and reads 0
    always_comb begin
        rs_data = 32'd0;
        rt_data = 32'd0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (inst.fs == 5'(i)) rs_data = regs_q[i];
            if (inst.ft == 5'(i)) rt_data = regs_q[i];
        end
    end

    // Single write port: a move (only in IDLE) or an FPU result (only in EXEC)
    always_comb begin
        rf_we   = move_wr || ex_reg_wr;
        rf_idx  = move_wr ? inst.fd : ex_fd;
        rf_data = move_wr ? bus.data_in : ex_result;
    end

    // Register file; out-of-range destinations match no entry and are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file must read 0 after reset, so it is reset.
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 32'd0;
        end else if (rf_we) begin
            for (int i = 0; i < REG_COUNT; i++)
                if (rf_idx == 5'(i)) regs_q[i] <= rf_data;
        end
    end

    // Condition flags and the done pulse following any register/flag write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= rf_we || ex_cc_wr;
            if (ex_cc_wr) begin
                for (int i = 0; i < FLAG_COUNT; i++)
                    if (ex_cc == 3'(i)) flags_q[i] <= ex_result[0];
            end
        end
    end

endmodule

// File: tb/tb_fp_coprocessor_mc.sv
// Directed bench: dut_a uses default parameters, dut_b uses REG_COUNT=16,
// FLAG_COUNT=4, FPU_LATENCY=1.
module tb_fp_coprocessor_mc;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_coprocessor_mc_if #(.FLAG_COUNT(8)) bus_a ();
    fp_coprocessor_mc_if #(.FLAG_COUNT(4)) bus_b ();

    fp_coprocessor_mc #(.REG_COUNT(32), .FLAG_COUNT(8), .FPU_LATENCY(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    fp_coprocessor_mc #(.REG_COUNT(16), .FLAG_COUNT(4), .FPU_LATENCY(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    function automatic logic [31:0] enc(input logic [5:0] opc, input logic [4:0] fmt,
                                        input logic [4:0] ft, input logic [4:0] fs,
                                        input logic [4:0] fd, input logic [5:0] fn);
        return {opc, fmt, ft, fs, fd, fn};
    endfunction

    function automatic logic [31:0] mtc1(input logic [4:0] fd);
        return enc(6'h11, 5'h04, 5'd0, 5'd0, fd, 6'h00);
    endfunction

    function automatic logic [31:0] add_s(input logic [4:0] fd, input logic [4:0] fs,
                                          input logic [4:0] ft);
        return enc(6'h11, 5'h10, ft, fs, fd, 6'h00);
    endfunction

    function automatic logic [31:0] c_eq(input logic [2:0] cc, input logic [4:0] fs,
                                         input logic [4:0] ft);
        return enc(6'h11, 5'h10, ft, fs, {cc, 2'b00}, 6'h32);
    endfunction

    // Non-COP1 word used only to steer fs for data_out reads
    function automatic logic [31:0] rd(input logic [4:0] fs);
        return enc(6'h00, 5'h00, 5'd0, fs, 5'd0, 6'h00);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.inst = rd(5'd0); bus_a.inst_valid = 1'b0; bus_a.data_in = 32'd0;
        bus_b.inst = rd(5'd0); bus_b.inst_valid = 1'b0; bus_b.data_in = 32'd0;
        step(); step();
        n_run++; if (bus_a.inst_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus_a.inst_ready); end
        n_run++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        n_run++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_a.done); end
        n_run++; if (bus_a.flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h want 00", bus_a.flags); end
        n_run++; if (bus_a.data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", bus_a.data_out); end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_exec();
        bus_a.inst_valid = 1'b1;
        bus_a.inst = mtc1(5'd1); bus_a.data_in = 32'h3F80_0000; step();
        bus_a.inst = mtc1(5'd2); bus_a.data_in = 32'h4000_0000; step();
        bus_a.inst = add_s(5'd3, 5'd1, 5'd2); step();
        bus_a.inst_valid = 1'b0;
        step();
        n_run++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL midexec_busy: got %b want 1", bus_a.busy); end
        #2 rst_n = 1'b0;
        #1;
        n_run++; if (bus_a.inst_ready !== 1'b1) begin n_fail++; $display("FAIL midexec_async_ready: got %b want 1", bus_a.inst_ready); end
        step();
        rst_n = 1'b1;
        step(); step(); step(); step();
        n_run++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL midexec_done: got %b want 0", bus_a.done); end
        for (int r = 1; r <= 3; r++) begin
            bus_a.inst = rd(5'(r)); #1;
            n_run++; if (bus_a.data_out !== 32'd0) begin n_fail++; $display("FAIL midexec_reg%0d: got %h want 0", r, bus_a.data_out); end
        end
    endtask

    task automatic test_back_to_back();
        bus_a.inst_valid = 1'b1;
        bus_a.inst = mtc1(5'd1); bus_a.data_in = 32'h3F80_0000; step();
        n_run++; if (bus_a.inst_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", bus_a.inst_ready); end
        n_run++; if (bus_a.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b want 1", bus_a.done); end
        bus_a.inst = mtc1(5'd2); bus_a.data_in = 32'h4000_0000; step();
        n_run++; if (bus_a.inst_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %b want 1", bus_a.inst_ready); end
        n_run++; if (bus_a.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b want 1", bus_a.done); end
        bus_a.inst_valid = 1'b0;
        bus_a.inst = rd(5'd2); #1;
        n_run++; if (bus_a.data_out !== 32'h4000_0000) begin n_fail++; $display("FAIL b2b_f2: got %h want 40000000", bus_a.data_out); end
        step();
        n_run++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end: got %b want 0", bus_a.done); end
        bus_a.inst = rd(5'd1); #1;
        n_run++; if (bus_a.data_out !== 32'h3F80_0000) begin n_fail++; $display("FAIL b2b_f1: got %h want 3f800000", bus_a.data_out); end
    endtask

    task automatic test_add_latency();
        int low_cnt  = 0;
        int busy_cnt = 0;
        int done_cnt = 0;
        int n        = 0;
        bus_a.inst_valid = 1'b1;
        bus_a.inst = add_s(5'd3, 5'd1, 5'd2);
        step();  // E0
        bus_a.inst = add_s(5'd4, 5'd3, 5'd1);  // held valid throughout EXEC
        for (int k = 0; k < 4; k++) begin
            if (bus_a.inst_ready === 1'b0) low_cnt++;
            if (bus_a.busy === 1'b1) busy_cnt++;
            if (bus_a.done === 1'b1) done_cnt++;
            step();
        end
        n_run++; if (low_cnt !== 4) begin n_fail++; $display("FAIL add_ready_low_cycles: got %0d want 4", low_cnt); end
        n_run++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want 4", busy_cnt); end
        n_run++; if (done_cnt !== 0) begin n_fail++; $display("FAIL add_early_done: got %0d want 0", done_cnt); end
        n_run++; if (bus_a.inst_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_back: got %b want 1", bus_a.inst_ready); end
        n_run++; if (bus_a.done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", bus_a.done); end
        n_run++; if (bus_a.data_out !== 32'h4040_0000) begin n_fail++; $display("FAIL add_f3: got %h want 40400000", bus_a.data_out); end
        step();  // second add.s accepted here
        bus_a.inst_valid = 1'b0;
        n_run++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL add2_accepted: got busy %b want 1", bus_a.busy); end
        n_run++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL add_single_pulse: got %b want 0", bus_a.done); end
        while (bus_a.done !== 1'b1 && n < 10) begin step(); n++; end
        n_run++; if (n !== 4) begin n_fail++; $display("FAIL add2_latency: got %0d want 4", n); end
        bus_a.inst = rd(5'd4); #1;
        n_run++; if (bus_a.data_out !== 32'h4080_0000) begin n_fail++; $display("FAIL add2_f4: got %h want 40800000", bus_a.data_out); end
    endtask

    task automatic test_compare();
        int n;
        bus_a.inst = c_eq(3'd3, 5'd1, 5'd1); bus_a.inst_valid = 1'b1; step();
        bus_a.inst_valid = 1'b0;
        n = 0; while (bus_a.done !== 1'b1 && n < 10) begin step(); n++; end
        n_run++; if (bus_a.flags !== 8'b0000_1000) begin n_fail++; $display("FAIL ceq_cc3: got %b want 00001000", bus_a.flags); end
        step();
        bus_a.inst = c_eq(3'd5, 5'd1, 5'd2); bus_a.inst_valid = 1'b1; step();
        bus_a.inst_valid = 1'b0;
        n = 0; while (bus_a.done !== 1'b1 && n < 10) begin step(); n++; end
        n_run++; if (n !== 4) begin n_fail++; $display("FAIL ceq_latency: got %0d want 4", n); end
        n_run++; if (bus_a.flags !== 8'b0000_1000) begin n_fail++; $display("FAIL ceq_flags: got %b want 00001000", bus_a.flags); end
        bus_a.inst = rd(5'd1); #1;
        n_run++; if (bus_a.data_out !== 32'h3F80_0000) begin n_fail++; $display("FAIL ceq_f1: got %h want 3f800000", bus_a.data_out); end
        bus_a.inst = rd(5'd2); #1;
        n_run++; if (bus_a.data_out !== 32'h4000_0000) begin n_fail++; $display("FAIL ceq_f2: got %h want 40000000", bus_a.data_out); end
        bus_a.inst = rd(5'd20); #1;
        n_run++; if (bus_a.data_out !== 32'd0) begin n_fail++; $display("FAIL ceq_f20: got %h want 0", bus_a.data_out); end
        step();
    endtask

    task automatic test_ignore_opcode();
        bus_a.inst = enc(6'h00, 5'h04, 5'd0, 5'd0, 5'd1, 6'h00);
        bus_a.data_in = 32'hDEAD_BEEF; bus_a.inst_valid = 1'b1; step();
        bus_a.inst_valid = 1'b0;
        n_run++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL ignore_done: got %b want 0", bus_a.done); end
        n_run++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b want 0", bus_a.busy); end
        bus_a.inst = rd(5'd1); #1;
        n_run++; if (bus_a.data_out !== 32'h3F80_0000) begin n_fail++; $display("FAIL ignore_f1: got %h want 3f800000", bus_a.data_out); end
        step();
    endtask

    task automatic test_out_of_range();
        bus_b.inst_valid = 1'b1;
        bus_b.inst = mtc1(5'd20); bus_b.data_in = 32'h1234_5678; step();
        n_run++; if (bus_b.done !== 1'b1) begin n_fail++; $display("FAIL oor_move_done: got %b want 1", bus_b.done); end
        bus_b.inst = mtc1(5'd1); bus_b.data_in = 32'h3F80_0000; step();
        bus_b.inst = mtc1(5'd2); bus_b.data_in = 32'h4000_0000; step();
        bus_b.inst = c_eq(3'd6, 5'd1, 5'd1); step();
        bus_b.inst_valid = 1'b0;
        n_run++; if (bus_b.busy !== 1'b1) begin n_fail++; $display("FAIL oor_cmp_busy: got %b want 1", bus_b.busy); end
        step();
        n_run++; if (bus_b.done !== 1'b1) begin n_fail++; $display("FAIL oor_cmp_done: got %b want 1", bus_b.done); end
        n_run++; if (bus_b.flags !== 4'b0000) begin n_fail++; $display("FAIL oor_flags: got %b want 0000", bus_b.flags); end
        bus_b.inst = rd(5'd20); #1;
        n_run++; if (bus_b.data_out !== 32'd0) begin n_fail++; $display("FAIL oor_read_f20: got %h want 0", bus_b.data_out); end
        step();
    endtask

    task automatic test_latency_one();
        bus_b.inst = add_s(5'd3, 5'd1, 5'd2); bus_b.inst_valid = 1'b1; step();
        bus_b.inst_valid = 1'b0;
        n_run++; if (bus_b.inst_ready !== 1'b0) begin n_fail++; $display("FAIL lat1_ready_low: got %b want 0", bus_b.inst_ready); end
        bus_b.inst = rd(5'd3);
        step();
        n_run++; if (bus_b.inst_ready !== 1'b1) begin n_fail++; $display("FAIL lat1_ready_back: got %b want 1", bus_b.inst_ready); end
        n_run++; if (bus_b.done !== 1'b1) begin n_fail++; $display("FAIL lat1_done: got %b want 1", bus_b.done); end
        n_run++; if (bus_b.data_out !== 32'h4040_0000) begin n_fail++; $display("FAIL lat1_f3: got %h want 40400000", bus_b.data_out); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_back_to_back();
        test_add_latency();
        test_compare();
        test_ignore_opcode();
        test_out_of_range();
        test_latency_one();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
